cmp_edge_conditioner: RTL and testbench

Digital conditioner that sits directly downstream of the comparator latch and consumes its single-bit `Out` as `cmp_in`. It performs three steps:

- synchronises the asynchronous comparator decision into `clk`;
- rejects chatter with a consecutive-cycle debounce;
- emits one-cycle rise/fall pulses and keeps a saturating count of debounced rising edges.

The block drives the remaining `uo_out` bits in the top level, so the comparator result becomes a usable digital event stream.

---
 rtl/cmp_edge_conditioner.sv | 96 +++++++++
 tb/tb_cmp_edge_conditioner.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_edge_conditioner.sv
// Comparator output conditioner: synchronises, debounces and converts the
// comparator decision into registered rise/fall strobes and a saturating rise count.
module cmp_edge_conditioner #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEBOUNCE_LEN = 8,
    parameter int unsigned CNT_W        = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             cmp_in,
    input  logic             clear,
    output logic             level_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam int unsigned      RUN_W    = $clog2(DEBOUNCE_LEN) + 1;
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DEBOUNCE_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [RUN_W-1:0]       run_q, run_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic                   cmp_sync;

    assign cmp_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], cmp_in};
        run_d   = run_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        count_d = count_q;
        ovf_d   = ovf_q;

        if (ena) begin
            if (cmp_sync == level_q) begin
                run_d = '0;
            end else if (run_q == RUN_LAST) begin
                level_d = cmp_sync;
                run_d   = '0;
                rise_d  = cmp_sync;
                fall_d  = ~cmp_sync;
            end else begin
                run_d = run_q + RUN_W'(1);
            end
        end

        // clear wins over a rise accepted in the same cycle; the strobe still fires
        if (clear) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (rise_d) begin
            if (count_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            run_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            run_q   <= run_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign level_out  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign count      = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_cmp_edge_conditioner.sv
// Bench for cmp_edge_conditioner: directed vector table, saturation and reset
// sequences, then random chatter against a sample-window reference model.
module tb_cmp_edge_conditioner;

    localparam int SS   = 2;
    localparam int DL   = 8;
    localparam int CW   = 6;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          ena;
    logic          cin;
    logic          clear;
    logic          level_out;
    logic          rise_pulse;
    logic          fall_pulse;
    logic [CW-1:0] count;
    logic          overflow;

    int total = 0;
    int bad   = 0;

    cmp_edge_conditioner #(
        .SYNC_STAGES (SS),
        .DEBOUNCE_LEN(DL),
        .CNT_W       (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .cmp_in    (cin),
        .clear     (clear),
        .level_out (level_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .count     (count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: level flips once the last DL enabled samples of the
    // synchronised input all disagree with the current level.
    bit syncq[$];
    bit win[$];
    bit m_level, m_rise, m_fall, m_ovf;
    int m_count;

    task automatic model_reset();
        syncq.delete();
        for (int i = 0; i < SS; i++) syncq.push_back(1'b0);
        win.delete();
        m_level = 1'b0;
        m_rise  = 1'b0;
        m_fall  = 1'b0;
        m_ovf   = 1'b0;
        m_count = 0;
    endtask

    task automatic model_edge();
        bit s;
        bit flip;
        bit dropped;
        s = syncq.pop_front();
        syncq.push_back(cin);
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (ena) begin
            win.push_back(s);
            if (win.size() > DL) dropped = win.pop_front();
            flip = (win.size() == DL);
            foreach (win[i]) if (win[i] == m_level) flip = 1'b0;
            if (flip) begin
                m_level = s;
                m_rise  = s;
                m_fall  = !s;
                win.delete();
            end
        end
        if (clear) begin
            m_count = 0;
            m_ovf   = 1'b0;
        end else if (m_rise) begin
            if (m_count == MAXC) m_ovf = 1'b1;
            else m_count = m_count + 1;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("model_level", int'(level_out), int'(m_level));
        chk("model_rise", int'(rise_pulse), int'(m_rise));
        chk("model_fall", int'(fall_pulse), int'(m_fall));
        chk("model_count", int'(count), m_count);
        chk("model_ovf", int'(overflow), int'(m_ovf));
        chk("rise_fall_excl", int'(rise_pulse & fall_pulse), 0);
    endtask

    task automatic apply(input bit c, input bit e, input bit cl, input int n);
        for (int k = 0; k < n; k++) begin
            cin   = c;
            ena   = e;
            clear = cl;
            @(posedge clk);
            model_edge();
            #1;
            check_model();
        end
    endtask

    task automatic chk_outs(input string nm, input bit lv, input bit r, input bit f,
                            input int c, input bit o);
        chk({nm, "_level"}, int'(level_out), int'(lv));
        chk({nm, "_rise"}, int'(rise_pulse), int'(r));
        chk({nm, "_fall"}, int'(fall_pulse), int'(f));
        chk({nm, "_count"}, int'(count), c);
        chk({nm, "_ovf"}, int'(overflow), int'(o));
    endtask

    typedef struct {
        bit c;
        bit e;
        bit cl;
        int n;
        bit lv;
        bit r;
        bit f;
        int cnt;
        bit o;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit c, bit e, bit cl, int n, bit lv, bit r, bit f, int cnt, bit o);
        vec_t v;
        v.c = c; v.e = e; v.cl = cl; v.n = n;
        v.lv = lv; v.r = r; v.f = f; v.cnt = cnt; v.o = o;
        return v;
    endfunction

    initial begin
        // latency of a rise and a fall
        vecs.push_back(mk(1, 1, 0, 9, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 1, 1, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 1, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 9, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 1, 0));
        // 7-cycle glitches are rejected
        for (int g = 0; g < 5; g++) begin
            vecs.push_back(mk(1, 1, 0, 7, 0, 0, 0, 1, 0));
            vecs.push_back(mk(0, 1, 0, 7, 0, 0, 0, 1, 0));
        end
        // clean 12-cycle pulses up to count 5
        vecs.push_back(mk(1, 1, 0, 12, 1, 0, 0, 2, 0));
        vecs.push_back(mk(0, 1, 0, 12, 0, 0, 0, 2, 0));
        vecs.push_back(mk(1, 1, 0, 12, 1, 0, 0, 3, 0));
        vecs.push_back(mk(0, 1, 0, 12, 0, 0, 0, 3, 0));
        vecs.push_back(mk(1, 1, 0, 12, 1, 0, 0, 4, 0));
        vecs.push_back(mk(0, 1, 0, 12, 0, 0, 0, 4, 0));
        vecs.push_back(mk(1, 1, 0, 12, 1, 0, 0, 5, 0));
        vecs.push_back(mk(0, 1, 0, 12, 0, 0, 0, 5, 0));
        // clear coincident with an accepted rise
        vecs.push_back(mk(1, 1, 0, 9, 0, 0, 0, 5, 0));
        vecs.push_back(mk(1, 1, 1, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 1, 0, 0, 0, 0));
        // freeze after 4 differing cycles, resume 4 cycles to flip
        vecs.push_back(mk(0, 1, 0, 6, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 20, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 3, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 1, 0, 0));
        // clear honoured while disabled
        vecs.push_back(mk(1, 1, 0, 12, 1, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 1, 1, 0, 0, 0, 0));
        // disable on the would-be accepting cycle holds the level
        vecs.push_back(mk(0, 1, 0, 9, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 5, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 1, 0, 0));

        rst_n = 1'b0;
        cin   = 1'b0;
        ena   = 1'b1;
        clear = 1'b0;
        model_reset();
        #12;
        chk_outs("reset", 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i].c, vecs[i].e, vecs[i].cl, vecs[i].n);
            chk_outs($sformatf("vec%0d", i), vecs[i].lv, vecs[i].r, vecs[i].f,
                     vecs[i].cnt, vecs[i].o);
        end

        // saturation: level is 0 and count 0 here
        for (int i = 1; i <= 65; i++) begin
            apply(1, 1, 0, 12);
            apply(0, 1, 0, 12);
            if (i == 63) chk_outs("sat63", 0, 0, 0, 63, 0);
            if (i == 64) chk_outs("sat64", 0, 0, 0, 63, 1);
            if (i == 65) chk_outs("sat65", 0, 0, 0, 63, 1);
        end

        // asynchronous reset in the middle of a debounce run
        apply(1, 1, 0, 5);
        #3;
        rst_n = 1'b0;
        #1;
        chk_outs("async_rst", 0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #1;
        chk_outs("rst_hold", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        apply(1, 1, 0, 9);
        chk_outs("post_rst9", 0, 0, 0, 0, 0);
        apply(1, 1, 0, 1);
        chk_outs("post_rst10", 1, 1, 0, 1, 0);
        apply(1, 1, 0, 1);
        chk_outs("post_rst11", 1, 0, 0, 1, 0);

        // random chatter with run lengths 1..20
        begin
            bit v;
            int cyc;
            int len;
            v   = 1'b1;
            cyc = 0;
            while (cyc < 3000) begin
                v   = ~v;
                len = $urandom_range(1, 20);
                for (int k = 0; k < len; k++) begin
                    apply(v, ($urandom_range(0, 15) != 0), ($urandom_range(0, 63) == 0), 1);
                end
                cyc += len;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
